// File: rtl/sdram_rd_checker_if.sv
// Read-checker bus: arm/length control, sdram_core read-burst stream and results.
// master drives start and the read burst (sequencer side); slave is the checker.
// Plain wires only; there is no clocking or handshake logic in the interface.
interface sdram_rd_checker_if #(
  parameter int SDR_DQ_WIDTH    = 16,
  parameter int APP_BURST_WIDTH = 10,
  parameter int ERR_CNT_WIDTH   = 8
);
  logic                       i_start;
  logic [APP_BURST_WIDTH-1:0] i_burst_len;
  logic [SDR_DQ_WIDTH-1:0]    rd_burst_data;
  logic                       rd_burst_data_valid;
  logic                       rd_burst_finish;
  logic                       o_busy;
  logic                       o_done;
  logic                       o_pass;
  logic                       o_fail;
  logic                       o_timeout;
  logic [ERR_CNT_WIDTH-1:0]   o_err_cnt;
  logic [APP_BURST_WIDTH-1:0] o_first_err_idx;
  logic [SDR_DQ_WIDTH-1:0]    o_first_err_data;
  logic                       o_led_pass;

  modport master (
    output i_start, i_burst_len, rd_burst_data, rd_burst_data_valid, rd_burst_finish,
    input  o_busy, o_done, o_pass, o_fail, o_timeout, o_err_cnt,
           o_first_err_idx, o_first_err_data, o_led_pass
  );

  modport slave (
    input  i_start, i_burst_len, rd_burst_data, rd_burst_data_valid, rd_burst_finish,
    output o_busy, o_done, o_pass, o_fail, o_timeout, o_err_cnt,
           o_first_err_idx, o_first_err_data, o_led_pass
  );
endinterface

// File: rtl/sdram_rd_checker.sv
// Checks an sdram_core read burst against the incrementing write pattern; reports verdict, errors, timeout.
// o_done pulses 2 cycles after the final beat (beat registered, then compared, then verdict).
// No backpressure: every beat offered by sdram_core is consumed; the checker can never stall the read.
module sdram_rd_checker #(
  parameter int                      SDR_DQ_WIDTH    = 16,
  parameter int                      APP_BURST_WIDTH = 10,
  parameter logic [SDR_DQ_WIDTH-1:0] DATA_SEED       = 16'h0001,
  parameter int                      TIMEOUT_CYCLES  = 1024,
  parameter int                      ERR_CNT_WIDTH   = 8
) (
  input logic               clk,
  input logic               rst,
  sdram_rd_checker_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [APP_BURST_WIDTH-1:0] len_q, len_d;
  logic [APP_BURST_WIDTH-1:0] idx_q, idx_d;
  logic [TW-1:0]              timer_q, timer_d;
  logic [ERR_CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
  logic                       first_seen_q, first_seen_d;
  logic [APP_BURST_WIDTH-1:0] first_idx_q, first_idx_d;
  logic [SDR_DQ_WIDTH-1:0]    first_dat_q, first_dat_d;
  logic                       timeout_q, timeout_d;
  logic                       short_q, short_d;
  logic                       pass_q, pass_d;
  logic                       fail_q, fail_d;

  // Registered copy of the read stream; only beats seen while checking are kept.
  logic                       beat_vld_q;
  logic [SDR_DQ_WIDTH-1:0]    beat_dat_q;
  logic                       fin_q;

  logic [SDR_DQ_WIDTH-1:0]    expect_dat;
  logic [APP_BURST_WIDTH-1:0] idx_inc;
  logic [TW-1:0]              timer_inc;
  logic                       mismatch;
  logic                       len_met;
  logic                       timeout_hit;
  logic                       exit_chk;
  logic                       verdict_fail;
  logic                       in_done;

  assign expect_dat  = DATA_SEED + SDR_DQ_WIDTH'(idx_q);
  assign mismatch    = beat_vld_q && (beat_dat_q != expect_dat);
  assign idx_inc     = idx_q + {{(APP_BURST_WIDTH-1){1'b0}}, beat_vld_q};
  assign len_met     = (idx_inc == len_q);
  assign timer_inc   = timer_q + 1'b1;
  // The timer restarts in the cycle a beat arrives, so counting that cycle as
  // the first idle step puts o_done exactly TIMEOUT_CYCLES after the last activity.
  assign timeout_hit = !bus.rd_burst_data_valid && (timer_inc >= TO_LAST);
  assign exit_chk    = len_met || fin_q || timeout_hit;
  // A registered beat still arriving in DONE came after the burst closed: overrun.
  assign verdict_fail = (err_cnt_q != '0) || timeout_q || short_q || beat_vld_q;
  assign in_done      = (state_q == S_DONE);

  // Capture the read stream one cycle ahead of the compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_vld_q <= 1'b0;
      beat_dat_q <= '0;
      fin_q      <= 1'b0;
    end else begin
      beat_vld_q <= (state_q == S_CHECK) && bus.rd_burst_data_valid;
      beat_dat_q <= bus.rd_burst_data;
      fin_q      <= (state_q == S_CHECK) && bus.rd_burst_finish;
    end
  end

  // Next-state logic: arm on start, compare and count in CHECK, settle verdict in DONE.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    err_cnt_d    = err_cnt_q;
    first_seen_d = first_seen_q;
    first_idx_d  = first_idx_q;
    first_dat_d  = first_dat_q;
    timeout_d    = timeout_q;
    short_d      = short_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          state_d      = S_CHECK;
          len_d        = bus.i_burst_len;
          idx_d        = '0;
          timer_d      = '0;
          err_cnt_d    = '0;
          first_seen_d = 1'b0;
          first_idx_d  = '0;
          first_dat_d  = '0;
          timeout_d    = 1'b0;
          short_d      = 1'b0;
          pass_d       = 1'b0;
          fail_d       = 1'b0;
        end
      end
      S_CHECK: begin
        idx_d   = idx_inc;
        timer_d = bus.rd_burst_data_valid ? '0 : timer_inc;
        if (mismatch) begin
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          if (!first_seen_q) begin
            first_seen_d = 1'b1;
            first_idx_d  = idx_q;
            first_dat_d  = beat_dat_q;
          end
        end
        if (exit_chk) begin
          state_d   = S_DONE;
          timeout_d = timeout_hit && !len_met && !fin_q;
          short_d   = fin_q && !len_met;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        pass_d  = !verdict_fail;
        fail_d  = verdict_fail;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset abandons any check without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      timer_q      <= '0;
      err_cnt_q    <= '0;
      first_seen_q <= 1'b0;
      first_idx_q  <= '0;
      first_dat_q  <= '0;
      timeout_q    <= 1'b0;
      short_q      <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      err_cnt_q    <= err_cnt_d;
      first_seen_q <= first_seen_d;
      first_idx_q  <= first_idx_d;
      first_dat_q  <= first_dat_d;
      timeout_q    <= timeout_d;
      short_q      <= short_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
    end
  end

  // During DONE the verdict is shown directly so it lines up with o_done.
  assign bus.o_busy           = (state_q == S_CHECK);
  assign bus.o_done           = in_done;
  assign bus.o_pass           = in_done ? !verdict_fail : pass_q;
  assign bus.o_fail           = in_done ? verdict_fail : fail_q;
  assign bus.o_timeout        = timeout_q;
  assign bus.o_err_cnt        = err_cnt_q;
  assign bus.o_first_err_idx  = first_idx_q;
  assign bus.o_first_err_data = first_dat_q;
  assign bus.o_led_pass       = bus.o_pass;

endmodule
